// File: rtl/acc_32b.sv
// Streaming signed accumulator built around the 32-bit ripple-carry adder.
// Beats are summed until in_last (or the MAX_TERMS limit), and the result
// with its overflow, count and truncation status is held on a valid/ready
// output until the consumer takes it.

// 32-bit ripple-carry adder: a chain of single-bit full adders.
module fa_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s
);
  logic [31:0] w_c;

  assign w_c[0] = c_in;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      assign s[gi] = a[gi] ^ b[gi] ^ w_c[gi];
      if (gi < 31) begin : g_carry
        assign w_c[gi+1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
      end
    end
  endgenerate
endmodule

module acc_32b #(
  parameter int MAX_TERMS = 784,
  parameter int SAT       = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [31:0]                   in_data,
  input  logic                                 in_first,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [31:0]                   out_sum,
  output logic                                 out_ovf,
  output logic [$clog2(MAX_TERMS+1)-1:0]       out_cnt,
  output logic                                 out_trunc
);
  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t                   r_state;
  logic signed [31:0]       r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_ovf;
  logic                     r_out_valid;
  logic signed [31:0]       r_out_sum;
  logic                     r_out_ovf;
  logic [CNT_W-1:0]         r_out_cnt;
  logic                     r_out_trunc;

  logic                     w_accept;
  logic                     w_start;
  logic signed [31:0]       w_a;
  logic signed [31:0]       w_s;
  logic                     w_ovf_now;
  logic signed [31:0]       w_acc_nxt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic                     w_ovf_nxt;
  logic                     w_at_max;
  logic                     w_end;

  // Clamp to the signed limits on overflow when saturating, otherwise wrap.
  function automatic logic signed [31:0] sat_or_wrap(
    input logic signed [31:0] a,
    input logic signed [31:0] s,
    input logic               ovf
  );
    if ((SAT != 0) && ovf)
      return a[31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    else
      return s;
  endfunction

  // No beat can enter while a result is waiting, nor while reset is held.
  assign in_ready  = (r_state != HOLD) && !reset;
  assign w_accept  = in_valid && in_ready;

  // A new vector begins on any beat from IDLE, or on in_first mid-vector.
  assign w_start   = (r_state == IDLE) || in_first;
  assign w_a       = w_start ? 32'sd0 : r_acc;

  fa_32b u_fa (
    .a    (w_a),
    .b    (in_data),
    .c_in (1'b0),
    .s    (w_s)
  );

  assign w_ovf_now = (w_a[31] == in_data[31]) && (w_s[31] != w_a[31]);
  assign w_acc_nxt = sat_or_wrap(w_a, w_s, w_ovf_now);
  assign w_cnt_nxt = w_start ? CNT_W'(1) : r_cnt + CNT_W'(1);
  assign w_ovf_nxt = w_start ? w_ovf_now : (r_ovf | w_ovf_now);
  assign w_at_max  = (w_cnt_nxt == MAX_CNT);
  assign w_end     = in_last || w_at_max;

  // Accumulation state machine with registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_cnt   <= '0;
      r_out_trunc <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACC: begin
          if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
            if (w_end) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
              r_out_sum   <= w_acc_nxt;
              r_out_ovf   <= w_ovf_nxt;
              r_out_cnt   <= w_cnt_nxt;
              r_out_trunc <= w_at_max && !in_last;
            end else begin
              r_state <= ACC;
            end
          end
        end
        HOLD: begin
          if (r_out_valid && out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
  assign out_cnt   = r_out_cnt;
  assign out_trunc = r_out_trunc;
endmodule
